// File: rtl/crossbar_pkg.sv
// Shared types and width helpers for the stream crossbar (switch and arbiter unit).
package crossbar_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } lock_state_e;

    // Index width that never collapses to zero bits for a single-port configuration.
    function automatic int unsigned idx_width(input int unsigned count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// Single-entry valid/ready output register carrying one beat (data, last, id).
module stream_reg_slice #(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned IdWidth   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [DataWidth-1:0] in_data,
    input  logic                 in_last,
    input  logic [IdWidth-1:0]   in_id,
    input  logic                 out_ready,
    output logic                 slot_free,
    output logic                 out_valid,
    output logic [DataWidth-1:0] out_data,
    output logic                 out_last,
    output logic [IdWidth-1:0]   out_id
);

    logic                 valid_q;
    logic [DataWidth-1:0] data_q;
    logic                 last_q;
    logic [IdWidth-1:0]   id_q;

    // The slot can take a new beat when empty or when its current beat leaves this cycle.
    assign slot_free = !valid_q || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            id_q    <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= in_data;
            last_q  <= in_last;
            id_q    <= in_id;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_id    = id_q;

endmodule

// File: rtl/crossbar_switch.sv
// Crossbar data path: per-master packet lock onto the granted slave, input mux,
// and registered master-side outputs.
module crossbar_switch
    import crossbar_pkg::*;
#(
    parameter int unsigned T_DATA_WIDTH = 8,
    parameter int unsigned S_DATA_COUNT = 2,
    parameter int unsigned M_DATA_COUNT = 3,
    localparam int unsigned T_ID___WIDTH = idx_width(S_DATA_COUNT),
    localparam int unsigned T_DEST_WIDTH = idx_width(M_DATA_COUNT)
) (
    input  logic                                        clk_i,
    input  logic                                        rst_in,
    input  logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0]   s_data_i,
    input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0]   s_dest_i,
    input  logic [S_DATA_COUNT-1:0]                     s_last_i,
    input  logic [S_DATA_COUNT-1:0]                     s_valid_i,
    output logic [S_DATA_COUNT-1:0]                     s_ready_o,
    input  logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0]   grant_i,
    input  logic [M_DATA_COUNT-1:0]                     grant_valid_i,
    output logic [M_DATA_COUNT-1:0][T_DATA_WIDTH-1:0]   m_data_o,
    output logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0]   m_id_o,
    output logic [M_DATA_COUNT-1:0]                     m_last_o,
    output logic [M_DATA_COUNT-1:0]                     m_valid_o,
    input  logic [M_DATA_COUNT-1:0]                     m_ready_i
);

    lock_state_e             state_q [M_DATA_COUNT];
    lock_state_e             state_d [M_DATA_COUNT];
    logic [T_ID___WIDTH-1:0] lock_q  [M_DATA_COUNT];
    logic [T_ID___WIDTH-1:0] lock_d  [M_DATA_COUNT];

    logic [M_DATA_COUNT-1:0]                   slot_free;
    logic [M_DATA_COUNT-1:0]                   load;
    logic [M_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] ld_data;
    logic [M_DATA_COUNT-1:0]                   ld_last;
    logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] ld_id;

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            for (int m = 0; m < M_DATA_COUNT; m++) begin
                state_q[m] <= StIdle;
                lock_q[m]  <= '0;
            end
        end else begin
            for (int m = 0; m < M_DATA_COUNT; m++) begin
                state_q[m] <= state_d[m];
                lock_q[m]  <= lock_d[m];
            end
        end
    end

    // Out-of-range grants match no slave index and so never lock.
    always_comb begin
        s_ready_o = '0;
        load      = '0;
        ld_data   = '0;
        ld_last   = '0;
        ld_id     = '0;
        for (int m = 0; m < M_DATA_COUNT; m++) begin
            state_d[m] = state_q[m];
            lock_d[m]  = lock_q[m];
            for (int j = 0; j < S_DATA_COUNT; j++) begin
                if (state_q[m] == StIdle) begin
                    if (grant_valid_i[m] && grant_i[m] == T_ID___WIDTH'(j) && s_valid_i[j]
                        && s_dest_i[j] == T_DEST_WIDTH'(m)) begin
                        state_d[m] = StBusy;
                        lock_d[m]  = T_ID___WIDTH'(j);
                    end
                end else if (lock_q[m] == T_ID___WIDTH'(j)) begin
                    // While locked, s_dest_i is ignored: beats follow the lock, not the dest.
                    s_ready_o[j] = s_ready_o[j] | slot_free[m];
                    if (s_valid_i[j] && slot_free[m]) begin
                        load[m]    = 1'b1;
                        ld_data[m] = s_data_i[j];
                        ld_last[m] = s_last_i[j];
                        ld_id[m]   = T_ID___WIDTH'(j);
                        if (s_last_i[j]) begin
                            state_d[m] = StIdle;
                        end
                    end
                end
            end
        end
    end

    for (genvar m = 0; m < M_DATA_COUNT; m++) begin : g_out
        stream_reg_slice #(
            .DataWidth(T_DATA_WIDTH),
            .IdWidth  (T_ID___WIDTH)
        ) u_slice (
            .clk      (clk_i),
            .rst_n    (rst_in),
            .load     (load[m]),
            .in_data  (ld_data[m]),
            .in_last  (ld_last[m]),
            .in_id    (ld_id[m]),
            .out_ready(m_ready_i[m]),
            .slot_free(slot_free[m]),
            .out_valid(m_valid_o[m]),
            .out_data (m_data_o[m]),
            .out_last (m_last_o[m]),
            .out_id   (m_id_o[m])
        );
    end

endmodule

// File: tb/tb_crossbar_switch.sv
// Directed bench for crossbar_switch with a per-master scoreboard of expected beats.
module tb_crossbar_switch;

    localparam int DW = 8;
    localparam int S  = 2;
    localparam int M  = 3;

    logic                 clk_i = 1'b0;
    logic                 rst_in;
    logic [S-1:0][DW-1:0] s_data_i;
    logic [S-1:0][1:0]    s_dest_i;
    logic [S-1:0]         s_last_i;
    logic [S-1:0]         s_valid_i;
    logic [S-1:0]         s_ready_o;
    logic [M-1:0][0:0]    grant_i;
    logic [M-1:0]         grant_valid_i;
    logic [M-1:0][DW-1:0] m_data_o;
    logic [M-1:0][0:0]    m_id_o;
    logic [M-1:0]         m_last_o;
    logic [M-1:0]         m_valid_o;
    logic [M-1:0]         m_ready_i;

    // Expected beats per master, packed as {data, id, last}.
    logic [9:0] exp_q [M][$];

    int checks = 0;
    int errors = 0;
    int cyc_a, cyc_b;
    bit seen;

    crossbar_switch #(
        .T_DATA_WIDTH(DW),
        .S_DATA_COUNT(S),
        .M_DATA_COUNT(M)
    ) dut (
        .clk_i        (clk_i),
        .rst_in       (rst_in),
        .s_data_i     (s_data_i),
        .s_dest_i     (s_dest_i),
        .s_last_i     (s_last_i),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .grant_i      (grant_i),
        .grant_valid_i(grant_valid_i),
        .m_data_o     (m_data_o),
        .m_id_o       (m_id_o),
        .m_last_o     (m_last_o),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Scoreboard: every beat leaving a master must be the next one expected there.
    always @(negedge clk_i) begin
        if (rst_in === 1'b1) begin
            for (int m = 0; m < M; m++) begin
                if (m_valid_o[m] && m_ready_i[m]) begin
                    if (exp_q[m].size() == 0) begin
                        chk($sformatf("unexpected_beat_m%0d", m), 32'(m_data_o[m]), 32'hFFFF);
                    end else begin
                        chk($sformatf("beat_m%0d", m), 32'({m_data_o[m], m_id_o[m], m_last_o[m]}),
                            32'(exp_q[m].pop_front()));
                    end
                end
            end
        end
    end

    // Sends n_send beats of an n_total-beat packet from slave s, locked to master m.
    // Beats at index >= alt_from carry dest alt_dest (when alt_from >= 0).
    task automatic send_packet(input int s, input int m, input logic [7:0] base,
                               input int n_total, input int n_send, input int alt_from,
                               input int alt_dest, output int cyc);
        logic acc;
        cyc = 0;
        for (int b = 0; b < n_send; b++) begin
            exp_q[m].push_back({base + 8'(b), 1'(s), (b == n_total - 1)});
        end
        grant_i[m]       = 1'(s);
        grant_valid_i[m] = 1'b1;
        for (int b = 0; b < n_send; b++) begin
            s_data_i[s]  = base + 8'(b);
            s_last_i[s]  = (b == n_total - 1);
            s_dest_i[s]  = (alt_from >= 0 && b >= alt_from) ? 2'(alt_dest) : 2'(m);
            s_valid_i[s] = 1'b1;
            acc = 1'b0;
            for (int c = 0; c < 50 && !acc; c++) begin
                @(negedge clk_i);
                acc = s_ready_o[s];
                @(posedge clk_i);
                #1;
                cyc++;
            end
            chk($sformatf("accept_s%0d_b%0d", s, b), 32'(acc), 32'd1);
        end
        s_valid_i[s]     = 1'b0;
        s_last_i[s]      = 1'b0;
        grant_valid_i[m] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in        = 1'b0;
        s_data_i      = '0;
        s_dest_i      = '0;
        s_last_i      = '0;
        s_valid_i     = '0;
        grant_i       = '0;
        grant_valid_i = '0;
        m_ready_i     = '1;

        // Reset state
        @(negedge clk_i);
        chk("rst_m_valid", 32'(m_valid_o), 32'd0);
        chk("rst_m_data", 32'(m_data_o), 32'd0);
        chk("rst_m_id", 32'(m_id_o), 32'd0);
        chk("rst_m_last", 32'(m_last_o), 32'd0);
        chk("rst_s_ready", 32'(s_ready_o), 32'd0);
        @(posedge clk_i);
        #1 rst_in = 1'b1;
        @(posedge clk_i);
        #1;

        // Single beat: slave 0 -> master 1, data A5, exact latencies
        exp_q[1].push_back({8'hA5, 1'b0, 1'b1});
        s_data_i[0]      = 8'hA5;
        s_dest_i[0]      = 2'd1;
        s_last_i[0]      = 1'b1;
        s_valid_i[0]     = 1'b1;
        grant_i[1]       = 1'b0;
        grant_valid_i[1] = 1'b1;
        @(negedge clk_i);
        chk("lock_cycle_no_ready", 32'(s_ready_o[0]), 32'd0);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("ready_at_t1", 32'(s_ready_o[0]), 32'd1);
        chk("not_valid_before_t2", 32'(m_valid_o[1]), 32'd0);
        @(posedge clk_i);
        #1;
        s_valid_i[0]     = 1'b0;
        s_last_i[0]      = 1'b0;
        grant_valid_i[1] = 1'b0;
        @(negedge clk_i);
        chk("single_valid", 32'(m_valid_o[1]), 32'd1);
        chk("single_data", 32'(m_data_o[1]), 32'hA5);
        chk("single_id", 32'(m_id_o[1]), 32'd0);
        chk("single_last", 32'(m_last_o[1]), 32'd1);
        chk("single_back_idle", 32'(s_ready_o), 32'd0);
        @(posedge clk_i);
        #1;

        // 4-beat packet slave 1 -> master 0 with a 3-cycle sink stall on beat 0x11
        seen = 1'b0;
        fork
            send_packet(1, 0, 8'h10, 4, 4, -1, 0, cyc_a);
            begin
                for (int c = 0; c < 40 && !seen; c++) begin
                    @(posedge clk_i);
                    #1;
                    if (m_valid_o[0] && m_data_o[0] == 8'h11) seen = 1'b1;
                end
                chk("stall_reached", 32'(seen), 32'd1);
                if (seen) begin
                    m_ready_i[0] = 1'b0;
                    for (int c = 0; c < 3; c++) begin
                        @(negedge clk_i);
                        chk("stall_hold_data", 32'(m_data_o[0]), 32'h11);
                        chk("stall_hold_valid", 32'(m_valid_o[0]), 32'd1);
                        @(posedge clk_i);
                        #1;
                    end
                end
                m_ready_i[0] = 1'b1;
            end
        join
        repeat (3) @(posedge clk_i);
        #1;

        // Parallel: slave 0 -> master 2 and slave 1 -> master 0, full rate each
        fork
            send_packet(0, 2, 8'h20, 4, 4, -1, 0, cyc_a);
            send_packet(1, 0, 8'h30, 4, 4, -1, 0, cyc_b);
        join
        chk("parallel_cycles_m2", 32'(cyc_a), 32'd5);
        chk("parallel_cycles_m0", 32'(cyc_b), 32'd5);
        repeat (2) @(posedge clk_i);
        #1;

        // Dest changes from 1 to 2 after the first beat; lock keeps beats on master 1
        send_packet(0, 1, 8'h40, 4, 4, 1, 2, cyc_a);
        chk("dest_change_cycles", 32'(cyc_a), 32'd5);
        @(negedge clk_i);
        chk("dest_change_m2_idle", 32'(m_valid_o[2]), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;

        // Reset pulse after beat 2 of 4 on master 2
        send_packet(0, 2, 8'h50, 4, 2, -1, 0, cyc_a);
        @(negedge clk_i);
        #1;
        rst_in = 1'b0;
        #1;
        chk("midrst_m_valid", 32'(m_valid_o), 32'd0);
        chk("midrst_m_data", 32'(m_data_o), 32'd0);
        chk("midrst_m_last", 32'(m_last_o), 32'd0);
        chk("midrst_s_ready", 32'(s_ready_o), 32'd0);
        @(posedge clk_i);
        #1 rst_in = 1'b1;
        @(negedge clk_i);
        chk("post_rst_idle_ready", 32'(s_ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        send_packet(0, 2, 8'h60, 2, 2, -1, 0, cyc_a);
        chk("post_rst_packet_cycles", 32'(cyc_a), 32'd3);
        repeat (2) @(posedge clk_i);
        #1;

        // Grant to a slave whose dest is another master: no lock
        s_data_i[1]      = 8'h77;
        s_dest_i[1]      = 2'd0;
        s_valid_i[1]     = 1'b1;
        s_last_i[1]      = 1'b1;
        grant_i[2]       = 1'b1;
        grant_valid_i[2] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            chk("mismatch_no_ready", 32'(s_ready_o), 32'd0);
            chk("mismatch_no_valid", 32'(m_valid_o), 32'd0);
            @(posedge clk_i);
            #1;
        end
        s_valid_i        = '0;
        s_last_i         = '0;
        grant_valid_i    = '0;

        repeat (3) @(posedge clk_i);
        #1;
        for (int m = 0; m < M; m++) begin
            chk($sformatf("drained_m%0d", m), 32'(exp_q[m].size()), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/crossbar_switch.md
# crossbar_switch

Data-path stage directly downstream of the per-master round-robin arbiters in the stream crossbar. Each master port consumes its arbiter's grant, locks onto the granted slave for one whole packet (through the beat carrying tlast), and routes that slave's data, last and id into a per-master output register. Ready is returned to exactly one slave per master. The block owns all packet-lock state and the output pipeline register, so the crossbar's master-side outputs are registered.

## Interface
- T_DATA_WIDTH, 8, data width per beat
- S_DATA_COUNT, 2, number of slave (input) ports
- M_DATA_COUNT, 3, number of master (output) ports
- T_ID___WIDTH (localparam), $clog2(S_DATA_COUNT), source id width
- T_DEST_WIDTH (localparam), $clog2(M_DATA_COUNT), destination width

Ports:
- clk_i  in  1  single clock, all state on rising edge
- rst_in  in  1  asynchronous reset, active low
- s_data_i  in  [T_DATA_WIDTH] x S_DATA_COUNT  slave beat data
- s_dest_i  in  [T_DEST_WIDTH] x S_DATA_COUNT  slave destination master
- s_last_i  in  S_DATA_COUNT  slave end-of-packet
- s_valid_i  in  S_DATA_COUNT  slave beat valid
- s_ready_o  out  S_DATA_COUNT  slave beat accepted when valid&ready
- grant_i  in  [T_ID___WIDTH] x M_DATA_COUNT  arbiter-chosen slave id per master
- grant_valid_i  in  M_DATA_COUNT  arbiter decision valid for new packet
- m_data_o  out  [T_DATA_WIDTH] x M_DATA_COUNT  master beat data
- m_id_o  out  [T_ID___WIDTH] x M_DATA_COUNT  source slave of beat
- m_last_o  out  M_DATA_COUNT  master end-of-packet
- m_valid_o  out  M_DATA_COUNT  master beat valid
- m_ready_i  in  M_DATA_COUNT  master sink ready

## Operation
- Per master m: FSM IDLE/BUSY plus lock register lock_id[m].
- IDLE -> BUSY when grant_valid_i[m] && s_valid_i[g] && s_dest_i[g]==m, g=grant_i[m]; lock_id[m] <= g. No beat is accepted in the lock cycle.
- BUSY: s_ready_o[lock_id] = slot_free[m], where slot_free = !m_valid_o[m] || m_ready_i[m]. Accepted beat loads data/last/id into output register.
- BUSY -> IDLE on accepted beat with s_last_i=1. Both state and register update on the same edge.
- Slave j ready only if some master is BUSY with lock_id==j; otherwise 0. s_dest_i is ignored while BUSY (lock holds); dest change mid-packet is a protocol error, beats still go to locked master.
- s_valid_i dropping mid-packet: master stays BUSY, no beat loaded, output may drain.
- Output register: m_valid_o set on load, cleared when m_ready_i && no new load; holds data stable while m_valid_o && !m_ready_i.
- Out-of-range grant_i (>= S_DATA_COUNT) in IDLE: ignored, stay IDLE.

## Timing
- Reset: all FSMs IDLE, lock_id 0, m_valid_o 0, m_last_o 0, m_data_o 0, m_id_o 0; s_ready_o 0 (combinational from IDLE state).
- Reset asserted mid-packet: immediate abort, partial packet discarded, no output beat.
- Lock latency: grant sampled cycle t, s_ready_o earliest t+1.
- Beat latency: accepted cycle t -> m_valid_o at t+1.
- Throughput: 1 beat/cycle/master while m_ready_i high; s_ready_o combinationally depends on m_ready_i.
- Packet gap: min 1 idle cycle between packets on a master (last beat cycle, then lock cycle), i.e. N-beat packet occupies N+1 cycles minimum.
- Masters independent; simultaneous locks on different masters by different slaves proceed in parallel.

## Structure
- Shared package crossbar_pkg: state enum (IDLE, BUSY) and width helper functions used by this block and the arbiter unit.
- Sub-module stream_reg_slice: single-entry valid/ready pipeline register (data, last, id), instantiated M_DATA_COUNT times.
- Top block holds FSMs, lock registers, input muxes, s_ready_o OR-reduction.

## Test plan
- Single-beat: slave 0 dest 1, grant_i[1]=0, grant_valid_i[1]=1, last=1, data 0xA5 -> s_ready_o[0] at t+1, m_valid_o[1]=1 m_data_o=0xA5 m_id_o=0 m_last_o=1 at t+2.
- 4-beat packet 0x10..0x13 with m_ready_i low for 3 cycles at beat 2 -> no loss/duplication, m_data_o held at 0x11, order preserved.
- Slaves 0->master 2 and 1->master 0 simultaneously -> both masters stream in parallel, each at 1 beat/cycle.
- s_dest_i changed from 1 to 2 mid-packet -> remaining beats still on master 1, master 2 idle.
- Reset pulse after beat 2 of 4 -> all outputs 0, FSM IDLE; next packet locks and delivers cleanly.
- grant_valid_i with grant_i pointing to slave whose dest differs -> no lock, s_ready_o stays 0.
